// File: rtl/bg_pkg.sv
// bg_pkg: shared types and constants for the background scene controller.
//   palette_t   - ten 12-bit RGB entries (4 bits per channel), floor first (MSB)
//   bg_state_t  - controller states
//   SCENE_ROM   - built-in scene palettes
//   LEVEL_MAX   - full brightness level (identity scaling)
//   scene_pal() - ROM lookup; indices outside the ROM fall back to scene 0
//   scale_chan()- one 4-bit channel scaled by a 0..16 brightness level
package bg_pkg;

  localparam int unsigned PAL_ENTRIES  = 10;
  localparam int unsigned PAL_CHANNELS = 30;
  localparam int unsigned PAL_W        = 120;
  localparam int unsigned ROM_SCENES   = 4;
  localparam logic [4:0]  LEVEL_MAX    = 5'd16;

  typedef struct packed {
    logic [11:0] floor;
    logic [11:0] plank;
    logic [11:0] carpet;
    logic [11:0] trim;
    logic [11:0] stone;
    logic [11:0] mortar;
    logic [11:0] window;
    logic [11:0] col_light;
    logic [11:0] col_base;
    logic [11:0] col_dark;
  } palette_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } bg_state_t;

  // Scene 0 is the power-on palette; scenes 1..3 are dungeon, garden, night.
  localparam palette_t SCENE_ROM [ROM_SCENES] = '{
    120'h642_420_80a_ff0_666_444_6cf_666_444_222,
    120'h321_210_502_a80_556_223_48c_778_445_112,
    120'h5a3_373_2c4_fe8_9a8_565_bef_dd9_aa6_553,
    120'h124_013_306_88c_334_112_ffa_557_334_001
  };

  function automatic palette_t scene_pal(input logic [7:0] idx);
    palette_t p;
    case (idx)
      8'd0:    p = SCENE_ROM[0];
      8'd1:    p = SCENE_ROM[1];
      8'd2:    p = SCENE_ROM[2];
      8'd3:    p = SCENE_ROM[3];
      default: p = SCENE_ROM[0];
    endcase
    return p;
  endfunction

  // (c * lvl) >> 4 with an 8-bit product; lvl never exceeds 16, so no overflow.
  function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] lvl);
    logic [7:0] prod;
    prod = 8'(c) * 8'(lvl);
    return prod[7:4];
  endfunction

endpackage

// File: rtl/bg_pal_scale.sv
// bg_pal_scale: combinational brightness scaling of a whole palette.
//   pal_in  - unscaled palette
//   level   - brightness 0..16 (16 = identity, 0 = black)
//   pal_out - every 4-bit channel replaced by (c * level) >> 4
module bg_pal_scale
  import bg_pkg::*;
(
  input  palette_t   pal_in,
  input  logic [4:0] level,
  output palette_t   pal_out
);

  logic [PAL_W-1:0] raw_s;
  logic [PAL_W-1:0] scaled_s;

  assign raw_s = pal_in;

  // Scale all thirty channels independently.
  always_comb begin
    scaled_s = '0;
    for (int i = 0; i < PAL_CHANNELS; i++) begin
      scaled_s[i*4 +: 4] = scale_chan(raw_s[i*4 +: 4], level);
    end
  end

  assign pal_out = scaled_s;

endmodule

// File: rtl/bg_scene_ctrl.sv
// bg_scene_ctrl: frame-synchronous scene/palette controller.
//   clk, rst   - pixel clock, asynchronous active-high reset
//   vblnk_in   - vertical blank; its rising edge is the frame tick
//   req        - scene-change request, held until ack
//   scene_id   - requested scene, sampled on acceptance
//   ack        - one-cycle completion pulse
//   busy       - high whenever the controller is not IDLE
//   scene_cur  - scene currently displayed
//   level      - brightness 0..16
//   pal_out    - registered, scaled palette for the background renderer
// Build option: define BG_SCENE_FADE_EN for fade-out/fade-in transitions.
// Without it the swap happens on the first tick after acceptance and level
// stays at 16.
module bg_scene_ctrl
  import bg_pkg::*;
#(
  parameter int unsigned FADE_DIV = 2,
  parameter int unsigned N_SCENES = 4,
  localparam int unsigned SCENE_W = (N_SCENES > 1) ? $clog2(N_SCENES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vblnk_in,
  input  logic               req,
  input  logic [SCENE_W-1:0] scene_id,
  output logic               ack,
  output logic               busy,
  output logic [SCENE_W-1:0] scene_cur,
  output logic [4:0]         level,
  output palette_t           pal_out
);

  localparam logic [7:0] DIV_LAST = 8'(FADE_DIV - 1);

  bg_state_t          state_r;
  logic [SCENE_W-1:0] scene_cur_r;
  logic [SCENE_W-1:0] scene_nxt_r;
  logic [4:0]         level_r;
  logic               ack_r;
  logic               busy_r;
  logic [7:0]         div_cnt_r;
  logic               vblnk_q_r;
  palette_t           pal_out_r;
  palette_t           pal_base_s;
  palette_t           pal_scaled_s;
  logic               tick_s;
  logic               step_s;

  assign tick_s = vblnk_in & ~vblnk_q_r;
  assign step_s = tick_s && (div_cnt_r == DIV_LAST);

  // Delay vblnk by one cycle for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q_r <= 1'b0;
    end else begin
      vblnk_q_r <= vblnk_in;
    end
  end

  // Scene-change FSM with step divider and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      scene_cur_r <= '0;
      scene_nxt_r <= '0;
      level_r     <= LEVEL_MAX;
      ack_r       <= 1'b0;
      busy_r      <= 1'b0;
      div_cnt_r   <= 8'd0;
    end else begin
      ack_r <= 1'b0;
      if (tick_s) begin
        div_cnt_r <= step_s ? 8'd0 : div_cnt_r + 8'd1;
      end
      case (state_r)
        IDLE: begin
          // req is still high while ack is out; only a req beyond that is new.
          if (req && !ack_r) begin
            if (scene_id != scene_cur_r) begin
              scene_nxt_r <= scene_id;
              busy_r      <= 1'b1;
              // Clearing here also discards a tick arriving with the request.
              div_cnt_r   <= 8'd0;
`ifdef BG_SCENE_FADE_EN
              state_r     <= FADE_OUT;
`else
              state_r     <= SWAP;
`endif
            end else begin
              ack_r <= 1'b1;
            end
          end
        end
`ifdef BG_SCENE_FADE_EN
        FADE_OUT: begin
          if (step_s) begin
            level_r <= level_r - 5'd1;
            if (level_r == 5'd1) begin
              state_r <= SWAP;
            end
          end
        end
        FADE_IN: begin
          if (step_s) begin
            level_r <= level_r + 5'd1;
            if (level_r == LEVEL_MAX - 5'd1) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              ack_r   <= 1'b1;
            end
          end
        end
`endif
        SWAP: begin
          if (tick_s) begin
            scene_cur_r <= scene_nxt_r;
`ifdef BG_SCENE_FADE_EN
            state_r     <= FADE_IN;
            div_cnt_r   <= 8'd0;
`else
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            ack_r       <= 1'b1;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          level_r <= LEVEL_MAX;
        end
      endcase
    end
  end

  assign pal_base_s = scene_pal(8'(scene_cur_r));

  bg_pal_scale u_scale (
    .pal_in  (pal_base_s),
    .level   (level_r),
    .pal_out (pal_scaled_s)
  );

  // Output palette register; scene and level only change together on ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pal_out_r <= scene_pal(8'd0);
    end else begin
      pal_out_r <= pal_scaled_s;
    end
  end

  assign ack       = ack_r;
  assign busy      = busy_r;
  assign scene_cur = scene_cur_r;
  assign level     = level_r;
  assign pal_out   = pal_out_r;

endmodule

// File: tb/tb_bg_scene_ctrl.sv
// Self-checking bench for bg_scene_ctrl and its palette scaler.
module tb_bg_scene_ctrl;
  import bg_pkg::*;

  localparam logic [119:0] SC0 = 120'h642_420_80a_ff0_666_444_6cf_666_444_222;
  localparam logic [119:0] SC1 = 120'h321_210_502_a80_556_223_48c_778_445_112;
  localparam logic [119:0] SC2 = 120'h5a3_373_2c4_fe8_9a8_565_bef_dd9_aa6_553;
  localparam logic [119:0] SC3 = 120'h124_013_306_88c_334_112_ffa_557_334_001;
  localparam logic [119:0] SC0_L8 = 120'h321_210_405_770_333_222_367_333_222_111;
`ifdef BG_SCENE_FADE_EN
  localparam int FULL_TICKS = 33;
`else
  localparam int FULL_TICKS = 1;
`endif

  typedef struct {
    logic [4:0]   lvl;
    logic [119:0] pal;
    logic [119:0] exp;
  } scale_vec_t;

  typedef struct {
    logic [1:0]   id;
    logic [119:0] pal;
  } scene_vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblnk_in;
  logic       req;
  logic [1:0] scene_id;
  logic       ack;
  logic       busy;
  logic [1:0] scene_cur;
  logic [4:0] level;
  palette_t   pal_out;

  palette_t   sc_pal;
  logic [4:0] sc_lvl;
  palette_t   sc_out;

  int         checks;
  int         errors;
  logic [1:0] cur_model;

  always #5 clk = ~clk;

  bg_scene_ctrl #(.FADE_DIV(1), .N_SCENES(4)) dut (
    .clk(clk), .rst(rst), .vblnk_in(vblnk_in), .req(req), .scene_id(scene_id),
    .ack(ack), .busy(busy), .scene_cur(scene_cur), .level(level), .pal_out(pal_out)
  );

`ifdef BG_SCENE_FADE_EN
  logic       req3;
  logic       ack3;
  logic       busy3;
  logic [1:0] scene_cur3;
  logic [4:0] level3;
  palette_t   pal_out3;

  bg_scene_ctrl #(.FADE_DIV(3), .N_SCENES(4)) dut3 (
    .clk(clk), .rst(rst), .vblnk_in(vblnk_in), .req(req3), .scene_id(scene_id),
    .ack(ack3), .busy(busy3), .scene_cur(scene_cur3), .level(level3), .pal_out(pal_out3)
  );
`endif

  bg_pal_scale u_scale (.pal_in(sc_pal), .level(sc_lvl), .pal_out(sc_out));

  task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One frame tick: a one-cycle vblnk pulse after an idle cycle; returns at the
  // negedge right after the tick edge.
  task automatic tick_once();
    @(negedge clk);
    vblnk_in = 1'b1;
    @(negedge clk);
    vblnk_in = 1'b0;
  endtask

  task automatic start_req(input logic [1:0] id);
    scene_id = id;
    req      = 1'b1;
    @(negedge clk);
    chk("accept busy", 120'(busy), 120'(1));
  endtask

  task automatic finish_transition(input logic [1:0] id, input logic [119:0] exp_pal);
    int n;
    n = 0;
    while (ack !== 1'b1 && n < 40) begin
      tick_once();
      n++;
    end
    chk("xfer ticks", 120'(n), 120'(FULL_TICKS));
    chk("xfer ack", 120'(ack), 120'(1));
    chk("xfer scene_cur", 120'(scene_cur), 120'(id));
    chk("xfer level", 120'(level), 120'(16));
    chk("xfer busy", 120'(busy), 120'(0));
    req = 1'b0;
    @(negedge clk);
    chk("xfer pal_out", pal_out, exp_pal);
    chk("xfer ack drop", 120'(ack), 120'(0));
    cur_model = id;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    scale_vec_t vecs [8];
    scene_vec_t svecs [3];
    int exp_lvl;

    checks = 0; errors = 0; cur_model = 2'd0;
    rst = 1'b1; vblnk_in = 1'b0; req = 1'b0; scene_id = 2'd0;
`ifdef BG_SCENE_FADE_EN
    req3 = 1'b0;
`endif

    vecs[0] = '{5'd16, SC0, SC0};
    vecs[1] = '{5'd0,  SC0, 120'h0};
    vecs[2] = '{5'd8,  {10{12'hf60}}, {10{12'h730}}};
    vecs[3] = '{5'd8,  SC0, SC0_L8};
    vecs[4] = '{5'd15, {10{12'hf1a}}, {10{12'he09}}};
    vecs[5] = '{5'd7,  {10{12'h9c3}}, {10{12'h351}}};
    vecs[6] = '{5'd1,  {10{12'hfff}}, 120'h0};
    vecs[7] = '{5'd12, {10{12'h8b4}}, {10{12'h683}}};
    svecs[0] = '{2'd1, SC1};
    svecs[1] = '{2'd2, SC2};
    svecs[2] = '{2'd0, SC0};

    for (int i = 0; i < 8; i++) begin
      sc_lvl = vecs[i].lvl;
      sc_pal = vecs[i].pal;
      #1;
      chk($sformatf("scale[%0d]", i), sc_out, vecs[i].exp);
    end

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst pal_out", pal_out, SC0);
    chk("rst floor", 120'(pal_out.floor), 120'(12'h642));
    chk("rst carpet", 120'(pal_out.carpet), 120'(12'h80a));
    chk("rst level", 120'(level), 120'(16));
    chk("rst busy", 120'(busy), 120'(0));
    chk("rst ack", 120'(ack), 120'(0));
    chk("rst scene_cur", 120'(scene_cur), 120'(0));
    rst = 1'b0;
    @(negedge clk);

`ifdef BG_SCENE_FADE_EN
    // Scene 2 with FADE_DIV=1, plus an ignored second id during FADE_OUT.
    start_req(2'd2);
    chk("f3 level start", 120'(level), 120'(16));
    for (int t = 1; t <= 33; t++) begin
      tick_once();
      exp_lvl = (t <= 16) ? 16 - t : ((t == 17) ? 0 : t - 17);
      chk($sformatf("f3 level t%0d", t), 120'(level), 120'(exp_lvl));
      chk($sformatf("f3 ack t%0d", t), 120'(ack), 120'(t == 33));
      if (t == 5) scene_id = 2'd3;
      if (t == 16) chk("f3 scene before swap", 120'(scene_cur), 120'(0));
      if (t == 17) chk("f3 scene at swap", 120'(scene_cur), 120'(2));
      if (t == 8) begin
        @(negedge clk);
        chk("f3 pal at level 8", pal_out, SC0_L8);
      end
    end
    chk("f3 final scene", 120'(scene_cur), 120'(2));
    chk("f3 final busy", 120'(busy), 120'(0));
    req = 1'b0;
    @(negedge clk);
    chk("f3 final pal", pal_out, SC2);
    cur_model = 2'd2;
`endif

    // Request for the displayed scene: ack next cycle, then a new id accepted
    // only in the cycle after ack.
    scene_id = cur_model;
    req = 1'b1;
    @(negedge clk);
    chk("same ack", 120'(ack), 120'(1));
    chk("same busy", 120'(busy), 120'(0));
    chk("same level", 120'(level), 120'(16));
    scene_id = 2'd3;
    @(negedge clk);
    chk("ack cycle ignores req", 120'(busy), 120'(0));
    chk("ack pulse one cycle", 120'(ack), 120'(0));
    @(negedge clk);
    chk("req after ack accepted", 120'(busy), 120'(1));
    finish_transition(2'd3, SC3);

    for (int i = 0; i < 3; i++) begin
      start_req(svecs[i].id);
      finish_transition(svecs[i].id, svecs[i].pal);
    end

    // Tick in the acceptance cycle is not counted; a held vblnk gives one tick.
    scene_id = 2'd2;
    req = 1'b1;
    vblnk_in = 1'b1;
    @(negedge clk);
    chk("acc-tick busy", 120'(busy), 120'(1));
    repeat (3) @(negedge clk);
    chk("held vblnk scene", 120'(scene_cur), 120'(cur_model));
    chk("held vblnk level", 120'(level), 120'(16));
    chk("held vblnk busy", 120'(busy), 120'(1));
    vblnk_in = 1'b0;
    finish_transition(2'd2, SC2);

    // A changed scene_id while busy is ignored.
    start_req(2'd1);
    scene_id = 2'd3;
    finish_transition(2'd1, SC1);

`ifdef BG_SCENE_FADE_EN
    // FADE_DIV=3: level steps on every 3rd tick; swap on the tick after level 0.
    scene_id = 2'd1;
    req3 = 1'b1;
    @(negedge clk);
    chk("d3 busy", 120'(busy3), 120'(1));
    for (int t = 1; t <= 97; t++) begin
      tick_once();
      exp_lvl = (t <= 48) ? 16 - t / 3 : ((t == 49) ? 0 : (t - 49) / 3);
      chk($sformatf("d3 level t%0d", t), 120'(level3), 120'(exp_lvl));
      chk($sformatf("d3 ack t%0d", t), 120'(ack3), 120'(t == 97));
      if (t == 48) chk("d3 scene before swap", 120'(scene_cur3), 120'(0));
      if (t == 49) chk("d3 scene at swap", 120'(scene_cur3), 120'(1));
    end
    req3 = 1'b0;

    // Reset at level 7 during FADE_IN.
    start_req(2'd2);
    for (int t = 1; t <= 24; t++) tick_once();
    chk("pre-reset level", 120'(level), 120'(7));
    chk("pre-reset busy", 120'(busy), 120'(1));
`else
    // Reset while waiting for the swap tick.
    start_req(2'd2);
`endif
    rst = 1'b1;
    #1;
    chk("mid rst busy", 120'(busy), 120'(0));
    chk("mid rst level", 120'(level), 120'(16));
    chk("mid rst scene_cur", 120'(scene_cur), 120'(0));
    chk("mid rst ack", 120'(ack), 120'(0));
    chk("mid rst pal_out", pal_out, SC0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick_once();
      chk("post rst no ack", 120'(ack), 120'(0));
      chk("post rst scene_cur", 120'(scene_cur), 120'(0));
      chk("post rst level", 120'(level), 120'(16));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
